// File: rtl/dp_job_arbiter_pkg.sv
// Shared definitions for the two-requester datapath job arbiter.
// State encodings, requester count and the default watchdog limit.
package dp_job_arbiter_pkg;

    localparam int N_REQ       = 2;
    localparam int DEF_TIMEOUT = 255;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ISSUE    = 3'd1;
    localparam logic [2:0] ST_WAIT_ACT = 3'd2;
    localparam logic [2:0] ST_RUN      = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;
    localparam logic [2:0] ST_ABORT    = 3'd5;

endpackage

// File: rtl/dp_job_arbiter_rr_arb2.sv
// Two-way round-robin winner select; purely combinational.
// lp is the index of the last granted requester, which loses a tie.
module rr_arb2
    import dp_job_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic             lp,
    output logic [N_REQ-1:0] win
);

    always_comb begin
        win = '0;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = lp ? 2'b01 : 2'b10;
            default: win = '0;
        endcase
    end

endmodule

// File: rtl/dp_job_arbiter.sv
// Arbitrates one datapath/controller pair between two requesters, issues a start
// pulse, tracks the controller's active flag and returns the registered result.
//
//  state    | meaning
//  IDLE     | no job; pick a winner when any req is high
//  ISSUE    | one-cycle dp_start to the controller
//  WAIT_ACT | waiting for dp_active to rise (watchdog running)
//  RUN      | controller busy; capture result when dp_active falls
//  DONE     | done pulse to the granted requester
//  ABORT    | done + err pulse, result forced to zero
module dp_job_arbiter
    import dp_job_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [7:0] req_x0,
    input  logic [7:0] req_x1,
    input  logic [1:0] req_on0,
    input  logic [1:0] req_on1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic       err,
    output logic [7:0] res_y,
    output logic [2:0] res_s,
    output logic       res_b,
    output logic [7:0] dp_x,
    output logic [1:0] dp_on,
    output logic       dp_start,
    input  logic       dp_active,
    input  logic [7:0] dp_y,
    input  logic [2:0] dp_s,
    input  logic       dp_b
);

    localparam logic [CNT_W-1:0] WD_MAX = CNT_W'(TIMEOUT);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [1:0]       win;
    logic             lp;
    logic [CNT_W-1:0] wd;
    logic [CNT_W-1:0] wd_inc;
    logic             wd_hit;

    rr_arb2 u_arb (
        .req (req),
        .lp  (lp),
        .win (win)
    );

    // Saturating increment: the watchdog parks at the limit instead of wrapping.
    assign wd_inc = (wd == WD_MAX) ? wd : wd + CNT_W'(1);
    assign wd_hit = (wd_inc == WD_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (|req) state_nxt = ST_ISSUE;
            ST_ISSUE:    state_nxt = ST_WAIT_ACT;
            ST_WAIT_ACT: begin
                if (dp_active)   state_nxt = ST_RUN;
                else if (wd_hit) state_nxt = ST_ABORT;
            end
            ST_RUN: begin
                if (!dp_active)  state_nxt = ST_DONE;
                else if (wd_hit) state_nxt = ST_ABORT;
            end
            ST_DONE:     state_nxt = ST_IDLE;
            ST_ABORT:    state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        dp_start = (state == ST_ISSUE);
        err      = (state == ST_ABORT);
        done     = (state == ST_DONE || state == ST_ABORT) ? gnt : 2'b00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt   <= '0;
            lp    <= 1'b1;
            wd    <= '0;
            dp_x  <= '0;
            dp_on <= '0;
            res_y <= '0;
            res_s <= '0;
            res_b <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        gnt   <= win;
                        lp    <= win[1];
                        dp_x  <= win[1] ? req_x1  : req_x0;
                        dp_on <= win[1] ? req_on1 : req_on0;
                    end
                end
                ST_ISSUE:    wd <= '0;
                ST_WAIT_ACT: wd <= dp_active ? '0 : wd_inc;
                ST_RUN: begin
                    if (!dp_active) begin
                        res_y <= dp_y;
                        res_s <= dp_s;
                        res_b <= dp_b;
                    end else begin
                        wd <= wd_inc;
                    end
                end
                ST_DONE, ST_ABORT: gnt <= '0;
                default: ;
            endcase
            // Clearing on entry makes the result already zero while err is shown.
            if (state_nxt == ST_ABORT) begin
                res_y <= '0;
                res_s <= '0;
                res_b <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dp_job_arbiter.sv
// Directed bench for dp_job_arbiter with a small controller model; expected
// completions are queued at stimulus time and checked when done pulses.
module tb_dp_job_arbiter;

    localparam int TO = 4;

    typedef struct {
        logic [1:0] gnt;
        logic [7:0] x;
        logic [1:0] on;
        logic       err;
        logic [7:0] y;
        logic [2:0] s;
        logic       b;
        int         act_len;
        int         cyc;
    } job_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = '0;
    logic [7:0] req_x0 = '0;
    logic [7:0] req_x1 = '0;
    logic [1:0] req_on0 = '0;
    logic [1:0] req_on1 = '0;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       err;
    logic [7:0] res_y;
    logic [2:0] res_s;
    logic       res_b;
    logic [7:0] dp_x;
    logic [1:0] dp_on;
    logic       dp_start;
    logic       dp_active = 1'b0;
    logic [7:0] dp_y = '0;
    logic [2:0] dp_s = '0;
    logic       dp_b = 1'b0;

    int   tests = 0;
    int   fails = 0;
    bit   x0_chg = 1'b0;
    job_t sb[$];

    dp_job_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_x0    (req_x0),
        .req_x1    (req_x1),
        .req_on0   (req_on0),
        .req_on1   (req_on1),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .res_y     (res_y),
        .res_s     (res_s),
        .res_b     (res_b),
        .dp_x      (dp_x),
        .dp_on     (dp_on),
        .dp_start  (dp_start),
        .dp_active (dp_active),
        .dp_y      (dp_y),
        .dp_s      (dp_s),
        .dp_b      (dp_b)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] g, input logic [7:0] x, input logic [1:0] on,
                        input logic e, input logic [7:0] y, input logic [2:0] s,
                        input logic b, input int act_len, input int cyc);
        job_t j;
        j.gnt = g; j.x = x; j.on = on; j.err = e;
        j.y = y; j.s = s; j.b = b; j.act_len = act_len; j.cyc = cyc;
        sb.push_back(j);
    endtask

    // Called in the IDLE cycle where req is driven (cycle 0); plays the controller.
    task automatic wait_done(input string tag, input int budget, input bit hold);
        job_t e;
        int   cyc;
        int   act_cnt;
        int   starts;
        bit   got;
        e = sb[0];
        cyc = 0; act_cnt = 0; starts = 0; got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            step();
            cyc++;
            if (act_cnt > 0) begin
                dp_active = 1'b1;
                act_cnt--;
            end else begin
                dp_active = 1'b0;
            end
            if (dp_start) begin
                starts++;
                chk({tag, "_start_gnt"}, gnt, e.gnt);
                chk({tag, "_dp_x"}, dp_x, e.x);
                chk({tag, "_dp_on"}, dp_on, e.on);
                act_cnt = e.act_len;
                dp_y = e.y; dp_s = e.s; dp_b = e.b;
                if (x0_chg) req_x0 = 8'hFF;
            end
            if (done != 2'b00) begin
                got = 1'b1;
                chk({tag, "_done"}, done, e.gnt);
                chk({tag, "_err"}, err, e.err);
                chk({tag, "_res_y"}, res_y, e.err ? 8'h00 : e.y);
                chk({tag, "_res_s"}, res_s, e.err ? 3'd0 : e.s);
                chk({tag, "_res_b"}, res_b, e.err ? 1'b0 : e.b);
                chk({tag, "_starts"}, starts, 1);
                chk({tag, "_dp_x_hold"}, dp_x, e.x);
                if (e.cyc > 0) chk({tag, "_latency"}, cyc, e.cyc);
            end
        end
        chk({tag, "_done_seen"}, got, 1'b1);
        void'(sb.pop_front());
        dp_active = 1'b0;
        if (!hold) req = 2'b00;
        step();
        chk({tag, "_gap_gnt"}, gnt, 2'b00);
        chk({tag, "_gap_done"}, done, 2'b00);
    endtask

    initial begin
        #3;
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_done", done, 2'b00);
        chk("rst_err", err, 1'b0);
        chk("rst_start", dp_start, 1'b0);
        chk("rst_dp_x", dp_x, 8'h00);
        chk("rst_res_y", res_y, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        step();

        // single job, active high for 3 cycles
        req_x0 = 8'h5A; req_on0 = 2'b10; req_x1 = 8'h99; req_on1 = 2'b01;
        req = 2'b01;
        push(2'b01, 8'h5A, 2'b10, 1'b0, 8'h3C, 3'd5, 1'b1, 3, 6);
        wait_done("single", 40, 1'b0);

        // minimum latency, requester 1 alone
        req_x1 = 8'hA7; req_on1 = 2'b01;
        req = 2'b10;
        push(2'b10, 8'hA7, 2'b01, 1'b0, 8'h81, 3'd2, 1'b0, 1, 4);
        wait_done("minlat", 40, 1'b0);

        // contention: both held high, grants must alternate
        req_x0 = 8'hC3; req_on0 = 2'b11; req_x1 = 8'h24; req_on1 = 2'b00;
        req = 2'b11;
        push(2'b01, 8'hC3, 2'b11, 1'b0, 8'h11, 3'd1, 1'b1, 2, 0);
        wait_done("cont_a", 40, 1'b1);
        push(2'b10, 8'h24, 2'b00, 1'b0, 8'h22, 3'd6, 1'b0, 2, 0);
        wait_done("cont_b", 40, 1'b1);
        push(2'b01, 8'hC3, 2'b11, 1'b0, 8'h33, 3'd7, 1'b1, 1, 0);
        wait_done("cont_c", 40, 1'b0);

        // operand stability: req_x0 changes after grant
        req_x0 = 8'h11; req_on0 = 2'b01;
        req = 2'b01;
        x0_chg = 1'b1;
        push(2'b01, 8'h11, 2'b01, 1'b0, 8'h44, 3'd3, 1'b0, 3, 6);
        wait_done("stable", 40, 1'b0);
        x0_chg = 1'b0;
        chk("stable_x0_changed", req_x0, 8'hFF);

        // watchdog: controller never responds
        req = 2'b01;
        push(2'b01, 8'hFF, 2'b01, 1'b1, 8'hEE, 3'd7, 1'b1, 0, 6);
        wait_done("wd_noresp", 40, 1'b0);

        // watchdog: controller stuck busy, then a normal job
        req_x1 = 8'h5C; req_on1 = 2'b10;
        req = 2'b10;
        push(2'b10, 8'h5C, 2'b10, 1'b1, 8'hEE, 3'd7, 1'b1, 100, 7);
        wait_done("wd_stuck", 40, 1'b0);
        req = 2'b10;
        push(2'b10, 8'h5C, 2'b10, 1'b0, 8'h9E, 3'd4, 1'b1, 2, 5);
        wait_done("after_abort", 40, 1'b0);

        // asynchronous reset in RUN
        req_x0 = 8'h66; req_on0 = 2'b11;
        req = 2'b01;
        step();
        chk("mid_issue_start", dp_start, 1'b1);
        step();
        dp_active = 1'b1;
        step();
        chk("mid_run_gnt", gnt, 2'b01);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_gnt", gnt, 2'b00);
        chk("mid_rst_start", dp_start, 1'b0);
        chk("mid_rst_done", done, 2'b00);
        chk("mid_rst_res_y", res_y, 8'h00);
        chk("mid_rst_res_s", res_s, 3'd0);
        chk("mid_rst_res_b", res_b, 1'b0);
        chk("mid_rst_dp_x", dp_x, 8'h00);
        dp_active = 1'b0;
        req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        step();
        req = 2'b11;
        push(2'b01, 8'h66, 2'b11, 1'b0, 8'h77, 3'd1, 1'b1, 1, 4);
        wait_done("post_rst", 40, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
